// File: rtl/pipeline_hazard_tracker_pkg.sv
// pipeline_hazard_tracker_pkg: shared widths, forwarding encodings and stage-entry type
package pipeline_hazard_tracker_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  rf_enable;
    logic                  load;
  } stage_entry_t;
  localparam stage_entry_t BUBBLE = '{dest: '0, rf_enable: 1'b0, load: 1'b0};
endpackage

// File: rtl/pipeline_hazard_tracker_stage_entry_reg.sv
// stage_entry_reg: one pipeline stage of destination tracking with bubble insert
module stage_entry_reg
  import pipeline_hazard_tracker_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_bubble,
  input  stage_entry_t i_d,
  output stage_entry_t o_q
);
  stage_entry_t r_q;
  // capture the upstream entry, or a bubble when squashed; active-low reset empties the stage
  always_ff @(posedge clk)
    r_q <= (!reset || i_bubble) ? BUBBLE : i_d;
  assign o_q = r_q;
endmodule

// File: rtl/pipeline_hazard_tracker.sv
// pipeline_hazard_tracker: EX/MEM/WB destination tracking, ID operand forwarding and stall statistics
module pipeline_hazard_tracker
  import pipeline_hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_W    = pipeline_hazard_tracker_pkg::REG_ADDR_W,
  parameter int DATA_W        = pipeline_hazard_tracker_pkg::DATA_W,
  parameter int STALL_CNT_W   = 16,
  parameter int MAX_STALL_RUN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_destination,
  input  logic                   id_rf_enable,
  input  logic                   id_load_instruction,
  input  logic                   nop_signal,
  input  logic                   load_enable,
  input  logic                   flush,
  input  logic [1:0]             pa_selector,
  input  logic [1:0]             pb_selector,
  input  logic [DATA_W-1:0]      rf_pa,
  input  logic [DATA_W-1:0]      rf_pb,
  input  logic [DATA_W-1:0]      ex_value,
  input  logic [DATA_W-1:0]      mem_value,
  input  logic [DATA_W-1:0]      wb_value,
  output logic [REG_ADDR_W-1:0]  ex_destination,
  output logic [REG_ADDR_W-1:0]  mem_destination,
  output logic [REG_ADDR_W-1:0]  wb_destination,
  output logic                   ex_rf_enable,
  output logic                   mem_rf_enable,
  output logic                   wb_rf_enable,
  output logic                   ex_load_instruction,
  output logic [DATA_W-1:0]      id_pa,
  output logic [DATA_W-1:0]      id_pb,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   stall_error
);
  // run counter saturates one past the legal limit so an overrun stays visible
  localparam int RUN_W = $clog2(MAX_STALL_RUN + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL_RUN);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL_RUN + 1);
  stage_entry_t w_id_entry, w_ex, w_mem, w_wb;
  logic w_bubble, w_stall, w_run_over, w_protocol_err;
  logic [RUN_W-1:0] r_run;
  logic [STALL_CNT_W-1:0] r_stall_count;
  logic r_stall_error;
  assign w_bubble       = nop_signal | flush;
  assign w_stall        = nop_signal & ~flush;
  assign w_run_over     = w_stall & (r_run >= RUN_MAX);
  assign w_protocol_err = ~load_enable & ~nop_signal;
  // writes to x0 never count as producers, but the load flag is kept for load-use detection
  assign w_id_entry = '{dest: id_destination, rf_enable: id_rf_enable & (id_destination != '0), load: id_load_instruction};
  stage_entry_reg u_ex  (.clk(clk), .reset(reset), .i_bubble(w_bubble), .i_d(w_id_entry), .o_q(w_ex));
  stage_entry_reg u_mem (.clk(clk), .reset(reset), .i_bubble(1'b0),     .i_d(w_ex),       .o_q(w_mem));
  stage_entry_reg u_wb  (.clk(clk), .reset(reset), .i_bubble(1'b0),     .i_d(w_mem),      .o_q(w_wb));
  // consecutive-bubble run length; a flushed cycle breaks the run
  always_ff @(posedge clk)
    if (!reset || !w_stall) r_run <= '0;
    else if (r_run != RUN_SAT) r_run <= r_run + 1'b1;
  // saturating count of real stall cycles
  always_ff @(posedge clk)
    if (!reset) r_stall_count <= '0;
    else if (w_stall && !(&r_stall_count)) r_stall_count <= r_stall_count + 1'b1;
  // sticky error on an over-long bubble run or a hold without a bubble
  always_ff @(posedge clk)
    if (!reset) r_stall_error <= 1'b0;
    else if (w_run_over || w_protocol_err) r_stall_error <= 1'b1;
  // zero-latency operand forwarding
  always_comb begin
    id_pa = pa_selector == SEL_RF ? rf_pa : pa_selector == SEL_EX ? ex_value : pa_selector == SEL_MEM ? mem_value : wb_value;
    id_pb = pb_selector == SEL_RF ? rf_pb : pb_selector == SEL_EX ? ex_value : pb_selector == SEL_MEM ? mem_value : wb_value;
  end
  assign ex_destination      = w_ex.dest;
  assign mem_destination     = w_mem.dest;
  assign wb_destination      = w_wb.dest;
  assign ex_rf_enable        = w_ex.rf_enable;
  assign mem_rf_enable       = w_mem.rf_enable;
  assign wb_rf_enable        = w_wb.rf_enable;
  assign ex_load_instruction = w_ex.load;
  assign stall_count         = r_stall_count;
  assign stall_error         = r_stall_error;
endmodule

// File: doc/pipeline_hazard_tracker.md
Name: pipeline_hazard_tracker

Overview:
- Produces the per-stage destination, write-enable and load flags that the hazard/forwarding unit compares against ID-stage source registers.
- Consumes that unit's stall, bubble and operand-select decisions.
- Holds the EX/MEM/WB destination shift pipeline and inserts bubbles.
- Drives the ID-stage operand forwarding muxes, counts stall cycles, and flags illegal stall runs.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers in the 5-stage core.

Parameters:
- REG_ADDR_W, 5, register-index width
- DATA_W, 32, operand width
- STALL_CNT_W, 16, width of the stall statistics counter
- MAX_STALL_RUN, 1, maximum legal consecutive bubble cycles

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-low reset
- id_destination  input  REG_ADDR_W  rd of the instruction in ID
- id_rf_enable  input  1  ID instruction writes the register file
- id_load_instruction  input  1  ID instruction is a load
- nop_signal  input  1  hazard unit requests a bubble into EX
- load_enable  input  1  hazard unit IF/ID hold control (1 = advance)
- flush  input  1  branch-taken flush; squashes the ID instruction
- pa_selector  input  2  operand A source: 00 = RF, 01 = EX, 10 = MEM, 11 = WB
- pb_selector  input  2  operand B source, same encoding
- rf_pa  input  DATA_W  register-file port A
- rf_pb  input  DATA_W  register-file port B
- ex_value  input  DATA_W  ALU result in EX
- mem_value  input  DATA_W  result in MEM
- wb_value  input  DATA_W  write-back value
- ex_destination  output  REG_ADDR_W  rd tracked in EX
- mem_destination  output  REG_ADDR_W  rd tracked in MEM
- wb_destination  output  REG_ADDR_W  rd tracked in WB
- ex_rf_enable  output  1  write flag tracked in EX
- mem_rf_enable  output  1  write flag tracked in MEM
- wb_rf_enable  output  1  write flag tracked in WB
- ex_load_instruction  output  1  EX holds a load
- id_pa  output  DATA_W  forwarded operand A
- id_pb  output  DATA_W  forwarded operand B
- stall_count  output  STALL_CNT_W  saturating count of bubble cycles
- stall_error  output  1  sticky; a bubble run exceeded MAX_STALL_RUN

Behaviour:
- Reset (reset == 0 at the clk edge): clear all stage destinations, enables, ex_load_instruction, stall_count, the run counter and stall_error. Reset takes priority over every other input. Reset mid-stall discards the pending bubble; id_pa/id_pb remain combinational.
- Every non-reset edge: WB stage <= MEM stage; MEM stage <= EX stage. Downstream stages never hold.
- EX capture: if nop_signal or flush, capture a bubble (dest 0, rf_enable 0, load 0). Otherwise capture id_destination, id_rf_enable, id_load_instruction.
- x0 suppression: an entry captured with id_destination == 0 has rf_enable forced to 0. A load to x0 still sets ex_load_instruction.
- load_enable is observed only for consistency. load_enable == 0 together with nop_signal == 0 is a protocol violation and sets stall_error.
- Latency: an ID entry appears on the ex_* outputs one cycle after capture, on mem_* after two cycles, and on wb_* after three.
- Forwarding muxes are purely combinational, zero latency. pa_selector selects rf_pa, ex_value, mem_value or wb_value; pb_selector selects the same way using rf_pb.
- stall_count: increments on each edge where nop_signal == 1 and flush == 0. It saturates at all-ones with no wrap.
- Run counter: increments while nop_signal persists and clears on the first cycle without it.
- stall_error: sets when the run counter would exceed MAX_STALL_RUN. It is sticky until reset.
- Simultaneous nop_signal and flush: a single bubble is inserted, not counted as a stall, and the run counter clears.

Decomposition:
- Shared package:
  - forwarding-select encodings SEL_RF, SEL_EX, SEL_MEM, SEL_WB
  - stage-entry struct {dest, rf_enable, load}
  - the BUBBLE entry constant
  - REG_ADDR_W and DATA_W
- One natural sub-module: stage_entry_reg, a single-stage register holding the entry with reset and bubble-insert capability. Instantiate it three times.
- The forwarding mux stays inline.

Test Plan:
- Reset held 2 cycles with random inputs -> all tracked outputs 0, stall_count 0, stall_error 0.
- Sequence id_destination 5, 6, 7 with rf_enable 1 and no stalls -> cycle 3 shows ex_destination 7, mem_destination 6, wb_destination 5, all enables 1.
- Load into rd 3 followed by nop_signal for 1 cycle -> EX shows a bubble, MEM shows dest 3 with load flag cleared downstream, stall_count 1, stall_error 0.
- nop_signal held 2 consecutive cycles with MAX_STALL_RUN 1 -> stall_error rises on the 2nd edge and stays 1 after nop_signal drops.
- id_destination 0 with id_rf_enable 1 -> ex_rf_enable 0. pa_selector 10 with mem_value 0xDEADBEEF -> id_pa 0xDEADBEEF in the same cycle.
- Preload stall_count to saturation and assert nop_signal together with flush -> stall_count holds at 0xFFFF, a single bubble is inserted, and reset mid-run clears everything next edge.
